hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose
//   Central hazard unit for the five-stage pipeline. It decides, every cycle,
//   whether the PC and the pipeline registers advance, hold, or take a bubble.
//   It also sequences multi-cycle memory accesses through a small FSM:
//   RUN -> WAIT -> (RUN | ERR -> RUN).
//
//   All state in this block updates on the FALLING edge of clk. This matches
//   the pipeline registers, so the combinational stall/flush decision has the
//   first half of the cycle to settle.
//
// Ports
//   clk            system clock (state updates on negedge)
//   rst            asynchronous, active-low reset
//   id_rreg1/2     source registers of the instruction in ID
//   id_use1/2      ID instruction really reads rreg1 / rreg2
//   exe_wreg       destination register of the instruction in EXE
//   exe_memread    EXE instruction is a load
//   exe_jump       branch/jump resolved taken in EXE
//   mem_imem       MEM stage uses instruction RAM (conflicts with fetch)
//   mem_busy       MEM stage needs a multi-cycle access
//   mem_ready      multi-cycle access is complete
//   pc_stall, ifid_stall, idexe_stall, exemem_stall
//                  hold the PC / named pipeline register
//   ifid_flush, idexe_flush
//                  load a bubble into IF/ID / ID/EXE
//   state          FSM state: RUN=00, WAIT=01, ERR=10
//   stall_cnt      saturating count of cycles with any stall or flush high
//   timeout        sticky flag, set when a WAIT ran out of patience
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rreg1,
    input  logic [3:0]  id_rreg2,
    input  logic        id_use1,
    input  logic        id_use2,
    input  logic [3:0]  exe_wreg,
    input  logic        exe_memread,
    input  logic        exe_jump,
    input  logic        mem_imem,
    input  logic        mem_busy,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idexe_stall,
    output logic        exemem_stall,
    output logic        ifid_flush,
    output logic        idexe_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    localparam logic [7:0]  LIMIT   = 8'(WAIT_LIMIT);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Control vector bit positions, kept together so the "any activity"
    // term for stall_cnt and the reset gating are single expressions.
    localparam int B_PC     = 5;
    localparam int B_IFID_S = 4;
    localparam int B_IDEX_S = 3;
    localparam int B_EXME_S = 2;
    localparam int B_IFID_F = 1;
    localparam int B_IDEX_F = 0;

    localparam logic [5:0] CTL_NONE     = 6'b000000;
    localparam logic [5:0] CTL_HOLD_ALL = 6'b111100; // every stage frozen
    localparam logic [5:0] CTL_BRANCH   = 6'b000011; // squash IF/ID and ID/EXE
    localparam logic [5:0] CTL_STRUCT   = 6'b100010; // hold PC, bubble into IF/ID
    localparam logic [5:0] CTL_LOADUSE  = 6'b110001; // hold PC+IF/ID, bubble into ID/EXE

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] stall_cnt_reg, stall_cnt_next;
    logic        timeout_reg, timeout_next;

    logic [5:0]  ctl_next;   // stall/flush decision before reset gating
    logic [5:0]  ctl_out;

    // -------------------------------------------------------------------------
    // Load-use detection: one comparator per ID source operand.
    // -------------------------------------------------------------------------
    logic [3:0] src_rreg [2];
    logic [1:0] src_use;
    logic [1:0] src_hit;
    logic       load_use;

    assign src_rreg[0] = id_rreg1;
    assign src_rreg[1] = id_rreg2;
    assign src_use     = {id_use2, id_use1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_hit[gi] = src_use[gi] && (src_rreg[gi] == exe_wreg);
        end
    endgenerate

    assign load_use = exe_memread && (|src_hit);

    // -------------------------------------------------------------------------
    // Next-state and stall/flush decision
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        ctl_next      = CTL_NONE;

        case (state_reg)
            ST_RUN: begin
                wait_cnt_next = 8'd0;
                // mem_busy owns the cycle even when it completes at once;
                // everything below it is suppressed.
                if (mem_busy) begin
                    if (!mem_ready) begin
                        ctl_next   = CTL_HOLD_ALL;
                        state_next = ST_WAIT;
                    end
                end else if (exe_jump) begin
                    // The wrong-path fetch and the ID instruction both die,
                    // so a structural or load-use hazard on them is moot.
                    ctl_next = CTL_BRANCH;
                end else if (mem_imem) begin
                    ctl_next = CTL_STRUCT;
                end else if (load_use) begin
                    ctl_next = CTL_LOADUSE;
                end
            end

            ST_WAIT: begin
                if (mem_ready) begin
                    // Stalls drop in the completing cycle. A load-use sitting
                    // in ID/EXE is picked up by the next RUN cycle.
                    state_next    = ST_RUN;
                    wait_cnt_next = 8'd0;
                end else begin
                    ctl_next = CTL_HOLD_ALL;
                    if ((wait_cnt_reg + 8'd1) >= LIMIT) begin
                        state_next    = ST_ERR;
                        timeout_next  = 1'b1;
                        wait_cnt_next = 8'd0;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
            end

            ST_ERR: begin
                // Drain the faulting access: let PC and EXE/MEM move, bubble
                // the two front registers once, then resume.
                ctl_next      = CTL_BRANCH;
                state_next    = ST_RUN;
                wait_cnt_next = 8'd0;
            end

            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if ((ctl_next != CTL_NONE) && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers (falling edge, asynchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= 8'd0;
            stall_cnt_reg <= 16'd0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Stall/flush are forced low while reset is held so that a
    // hazard on the inputs cannot leak out during reset.
    // -------------------------------------------------------------------------
    assign ctl_out      = rst ? ctl_next : CTL_NONE;

    assign pc_stall     = ctl_out[B_PC];
    assign ifid_stall   = ctl_out[B_IFID_S];
    assign idexe_stall  = ctl_out[B_IDEX_S];
    assign exemem_stall = ctl_out[B_EXME_S];
    assign ifid_flush   = ctl_out[B_IFID_F];
    assign idexe_flush  = ctl_out[B_IDEX_F];

    assign state        = state_reg;
    assign stall_cnt    = stall_cnt_reg;
    assign timeout      = timeout_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Two hazard_ctrl instances share one stimulus stream: dut_a with the default
// WAIT_LIMIT and dut_b with WAIT_LIMIT=4. Each cycle the driver computes the
// expected response from a rule-level reference model and queues it; an
// independent monitor pops one entry per cycle and compares it with both DUTs.
// DUT state changes on negedge; the driver works at posedge, the monitor
// samples 2 time units after posedge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int LIM_A = 255;
    localparam int LIM_B = 4;

    logic       clk;
    logic       rst;
    logic [3:0] id_rreg1, id_rreg2, exe_wreg;
    logic       id_use1, id_use2, exe_memread, exe_jump;
    logic       mem_imem, mem_busy, mem_ready;

    logic        pc_stall_a, ifid_stall_a, idexe_stall_a, exemem_stall_a;
    logic        ifid_flush_a, idexe_flush_a, timeout_a;
    logic [1:0]  state_a;
    logic [15:0] stall_cnt_a;
    logic        pc_stall_b, ifid_stall_b, idexe_stall_b, exemem_stall_b;
    logic        ifid_flush_b, idexe_flush_b, timeout_b;
    logic [1:0]  state_b;
    logic [15:0] stall_cnt_b;

    logic [5:0] out_a, out_b;
    assign out_a = {pc_stall_a, ifid_stall_a, idexe_stall_a, exemem_stall_a, ifid_flush_a, idexe_flush_a};
    assign out_b = {pc_stall_b, ifid_stall_b, idexe_stall_b, exemem_stall_b, ifid_flush_b, idexe_flush_b};

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst),
        .id_rreg1(id_rreg1), .id_rreg2(id_rreg2), .id_use1(id_use1), .id_use2(id_use2),
        .exe_wreg(exe_wreg), .exe_memread(exe_memread), .exe_jump(exe_jump),
        .mem_imem(mem_imem), .mem_busy(mem_busy), .mem_ready(mem_ready),
        .pc_stall(pc_stall_a), .ifid_stall(ifid_stall_a), .idexe_stall(idexe_stall_a),
        .exemem_stall(exemem_stall_a), .ifid_flush(ifid_flush_a), .idexe_flush(idexe_flush_a),
        .state(state_a), .stall_cnt(stall_cnt_a), .timeout(timeout_a)
    );

    hazard_ctrl #(.WAIT_LIMIT(LIM_B)) dut_b (
        .clk(clk), .rst(rst),
        .id_rreg1(id_rreg1), .id_rreg2(id_rreg2), .id_use1(id_use1), .id_use2(id_use2),
        .exe_wreg(exe_wreg), .exe_memread(exe_memread), .exe_jump(exe_jump),
        .mem_imem(mem_imem), .mem_busy(mem_busy), .mem_ready(mem_ready),
        .pc_stall(pc_stall_b), .ifid_stall(ifid_stall_b), .idexe_stall(idexe_stall_b),
        .exemem_stall(exemem_stall_b), .ifid_flush(ifid_flush_b), .idexe_flush(idexe_flush_b),
        .state(state_b), .stall_cnt(stall_cnt_b), .timeout(timeout_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] r1;
        logic [3:0] r2;
        logic       u1;
        logic       u2;
        logic [3:0] wreg;
        logic       memread;
        logic       jump;
        logic       imem;
        logic       busy;
        logic       ready;
    } stim_t;

    // mode: 0 running, 1 waiting on memory, 2 error drain
    typedef struct {
        int mode;
        int wcnt;
        int cnt;
        bit tmo;
    } mst_t;

    typedef struct {
        int          id;
        logic [5:0]  o_a, o_b;
        logic [1:0]  st_a, st_b;
        logic [15:0] c_a, c_b;
        logic        t_a, t_b;
    } exp_t;

    exp_t sb_q[$];
    mst_t m_a, m_b;
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rule-level reference: one call = one clock cycle.
    // Output vector order: pc, ifid_stall, idexe_stall, exemem_stall, ifid_flush, idexe_flush.
    task automatic model_step(input int limit, input mst_t cur, input stim_t s,
                              output logic [5:0] o, output mst_t nxt);
        bit lu;
        nxt = cur;
        o   = 6'b0;
        lu  = s.memread && ((s.u1 && s.r1 == s.wreg) || (s.u2 && s.r2 == s.wreg));
        case (cur.mode)
            0: begin
                if (s.busy) begin
                    if (!s.ready) begin
                        o = 6'b111100;
                        nxt.mode = 1;
                        nxt.wcnt = 0;
                    end
                end else if (s.jump) o = 6'b000011;
                else if (s.imem)     o = 6'b100010;
                else if (lu)         o = 6'b110001;
            end
            1: begin
                if (s.ready) begin
                    nxt.mode = 0;
                    nxt.wcnt = 0;
                end else begin
                    o = 6'b111100;
                    if (cur.wcnt + 1 >= limit) begin
                        nxt.mode = 2;
                        nxt.tmo  = 1'b1;
                        nxt.wcnt = 0;
                    end else begin
                        nxt.wcnt = cur.wcnt + 1;
                    end
                end
            end
            default: begin
                o = 6'b000011;
                nxt.mode = 0;
            end
        endcase
        if (o != 6'b0 && cur.cnt < 65535) nxt.cnt = cur.cnt + 1;
    endtask

    task automatic drive(input stim_t s);
        id_rreg1 = s.r1;  id_rreg2 = s.r2;
        id_use1 = s.u1;   id_use2 = s.u2;
        exe_wreg = s.wreg; exe_memread = s.memread; exe_jump = s.jump;
        mem_imem = s.imem; mem_busy = s.busy; mem_ready = s.ready;
    endtask

    task automatic model_reset();
        m_a = '{mode: 0, wcnt: 0, cnt: 0, tmo: 1'b0};
        m_b = '{mode: 0, wcnt: 0, cnt: 0, tmo: 1'b0};
    endtask

    // Called at a posedge: drive one cycle, queue expectation, wait next posedge.
    task automatic apply(input stim_t s);
        exp_t e;
        mst_t na, nb;
        logic [5:0] oa, ob;
        drive(s);
        model_step(LIM_A, m_a, s, oa, na);
        model_step(LIM_B, m_b, s, ob, nb);
        e.id   = txn;
        e.o_a  = oa;               e.o_b  = ob;
        e.st_a = 2'(m_a.mode);     e.st_b = 2'(m_b.mode);
        e.c_a  = 16'(m_a.cnt);     e.c_b  = 16'(m_b.cnt);
        e.t_a  = m_a.tmo;          e.t_b  = m_b.tmo;
        sb_q.push_back(e);
        txn++;
        m_a = na;
        m_b = nb;
        @(posedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_a"}, 32'(out_a), 32'd0);
        check({tag, "_out_b"}, 32'(out_b), 32'd0);
        check({tag, "_state_a"}, 32'(state_a), 32'd0);
        check({tag, "_state_b"}, 32'(state_b), 32'd0);
        check({tag, "_cnt_a"}, 32'(stall_cnt_a), 32'd0);
        check({tag, "_cnt_b"}, 32'(stall_cnt_b), 32'd0);
        check({tag, "_tmo_a"}, 32'(timeout_a), 32'd0);
        check({tag, "_tmo_b"}, 32'(timeout_b), 32'd0);
        $display("reset check %s: state_a=%0d state_b=%0d out_a=%b out_b=%b", tag, state_a, state_b, out_a, out_b);
    endtask

    // Called at a posedge: assert reset between clock edges with a hazard on
    // the inputs, check before the next edge, then release at the next posedge.
    task automatic mid_reset();
        stim_t h;
        h = '0;
        h.memread = 1'b1; h.wreg = 4'd3; h.r1 = 4'd3; h.u1 = 1'b1; h.busy = 1'b1;
        drive(h);
        #3 rst = 1'b0;
        #1 reset_checks("midwait");
        model_reset();
        @(posedge clk);
        rst = 1'b1;
    endtask

    // Monitor: one comparison set per queued transaction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_a",   32'(out_a),       32'(e.o_a));
                check("out_b",   32'(out_b),       32'(e.o_b));
                check("state_a", 32'(state_a),     32'(e.st_a));
                check("state_b", 32'(state_b),     32'(e.st_b));
                check("cnt_a",   32'(stall_cnt_a), 32'(e.c_a));
                check("cnt_b",   32'(stall_cnt_b), 32'(e.c_b));
                check("tmo_a",   32'(timeout_a),   32'(e.t_a));
                check("tmo_b",   32'(timeout_b),   32'(e.t_b));
                $display("txn %0d: st_a=%0d st_b=%0d out_a=%b out_b=%b cnt_a=%0d cnt_b=%0d tmo_b=%0d",
                         e.id, state_a, state_b, out_a, out_b, stall_cnt_a, stall_cnt_b, timeout_b);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        stim_t s;
        rst = 1'b0;
        s = '0;
        drive(s);
        model_reset();

        // Power-on reset: hazards on the inputs must not reach the outputs.
        @(posedge clk);
        s = '0;
        s.memread = 1'b1; s.wreg = 4'd3; s.r1 = 4'd3; s.u1 = 1'b1; s.jump = 1'b1; s.imem = 1'b1;
        drive(s);
        #1 reset_checks("por");
        @(posedge clk);
        rst = 1'b1;

        // Load-use on rreg1, then a bubble cycle.
        s = '0; s.memread = 1'b1; s.wreg = 4'd3; s.r1 = 4'd3; s.u1 = 1'b1; apply(s);
        s = '0; apply(s);
        // Register match but not used / not a load.
        s = '0; s.memread = 1'b1; s.wreg = 4'd5; s.r1 = 4'd5; s.r2 = 4'd5; apply(s);
        s = '0; s.wreg = 4'd5; s.r2 = 4'd5; s.u2 = 1'b1; apply(s);
        // Load-use on rreg2.
        s.memread = 1'b1; apply(s);
        // Branch together with load-use, and with a structural conflict.
        s = '0; s.jump = 1'b1; s.memread = 1'b1; s.wreg = 4'd7; s.r1 = 4'd7; s.u1 = 1'b1; apply(s);
        s = '0; s.jump = 1'b1; s.imem = 1'b1; apply(s);
        // Structural beats load-use.
        s = '0; s.imem = 1'b1; s.memread = 1'b1; s.wreg = 4'd2; s.r2 = 4'd2; s.u2 = 1'b1; apply(s);
        // Single-cycle memory completion.
        s = '0; s.busy = 1'b1; s.ready = 1'b1; apply(s);
        // Busy for 5 cycles then ready (dut_b times out along the way).
        s = '0; s.busy = 1'b1; repeat (5) apply(s);
        s.ready = 1'b1; apply(s);
        s = '0; apply(s);
        // Long hold without ready: dut_b goes WAIT -> ERR -> RUN -> WAIT.
        s = '0; s.busy = 1'b1; repeat (7) apply(s);
        s.ready = 1'b1; apply(s);
        s = '0; apply(s);
        // Load-use pending while waiting must be seen after the wait ends.
        s = '0; s.busy = 1'b1; s.memread = 1'b1; s.wreg = 4'd9; s.r1 = 4'd9; s.u1 = 1'b1;
        apply(s); apply(s);
        s.ready = 1'b1; apply(s);
        s.busy = 1'b0; s.ready = 1'b0; apply(s);
        s.memread = 1'b0; apply(s);
        // Asynchronous reset in the middle of a wait.
        s = '0; s.busy = 1'b1; repeat (3) apply(s);
        mid_reset();
        s = '0; apply(s);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            s.r1      = 4'($urandom_range(0, 3));
            s.r2      = 4'($urandom_range(0, 3));
            s.wreg    = 4'($urandom_range(0, 3));
            s.u1      = 1'($urandom_range(0, 1));
            s.u2      = 1'($urandom_range(0, 1));
            s.memread = 1'($urandom_range(0, 1));
            s.jump    = ($urandom_range(0, 5) == 0);
            s.imem    = ($urandom_range(0, 5) == 0);
            s.busy    = ($urandom_range(0, 7) == 0);
            s.ready   = ($urandom_range(0, 2) == 0);
            if (s.busy && s.ready) begin
                s.jump = 1'b0; s.imem = 1'b0; s.memread = 1'b0;
            end
            apply(s);
        end

        s = '0;
        drive(s);
        repeat (2) @(posedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
